// File: rtl/activation_pipe.sv
// -----------------------------------------------------------------------------
// activation_pipe
//
// Two-stage pipelined, element-wise activation unit. It takes one vector of
// LANES signed fixed-point elements per beat over a valid/ready handshake and
// applies the activation selected for that beat. The result leaves two cycles
// after acceptance. The unit runs at full throughput and holds two beats when
// the output is stalled.
//
// Modes (in_mode):
//   0 bypass       : y = x
//   1 ReLU         : y = (x < 0) ? 0 : x
//   2 leaky ReLU   : y = (x < 0) ? x >>> LEAK_SHIFT : x
//   3 clipped ReLU : y = clamp(x, 0, CLIP_VAL)
//
// Optional feature macro: ACTIVATION_PIPE_STATS_EN
//   When defined, stat_neg_cnt counts the negative elements of every accepted
//   beat. The count saturates at 2^32-1, and stat_clr clears it (clear wins
//   over a coincident beat). When undefined, stat_neg_cnt is tied to 0 and
//   stat_clr is ignored.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   input beat present
//   in_ready     out  beat can be accepted this cycle
//   in_data      in   LANES x DATA_W packed vector, lane i at [i*DATA_W +: DATA_W]
//   in_mode      in   activation mode for this beat
//   out_valid    out  output beat present
//   out_ready    in   downstream accepts
//   out_data     out  LANES x DATA_W packed result
//   stat_clr     in   clear negative-element counter
//   stat_neg_cnt out  negative-element counter
// -----------------------------------------------------------------------------
module activation_pipe #(
  parameter int     LANES      = 8,
  parameter int     DATA_W     = 32,
  parameter int     FRAC_W     = 16,
  parameter int     LEAK_SHIFT = 3,
  parameter longint CLIP_VAL   = 64'(6) << FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    stat_clr,
  output logic [31:0]             stat_neg_cnt
);

  localparam logic signed [DATA_W-1:0] CLIP_S = DATA_W'(CLIP_VAL);
  localparam int                       CNT_W  = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLIP   = 2'd3
  } mode_e;

  // Per-element activation. The leaky path needs no saturation because an
  // arithmetic right shift of any negative value stays representable.
  function automatic logic signed [DATA_W-1:0] f_activate(
    input logic signed [DATA_W-1:0] x,
    input logic                     neg,
    input mode_e                    mode
  );
    logic signed [DATA_W-1:0] y;
    y = x;
    case (mode)
      MODE_BYPASS: y = x;
      MODE_RELU:   y = neg ? '0 : x;
      MODE_LEAKY:  y = neg ? (x >>> LEAK_SHIFT) : x;
      MODE_CLIP: begin
        if (neg)              y = '0;
        else if (x > CLIP_S)  y = CLIP_S;
        else                  y = x;
      end
      default:     y = x;
    endcase
    return y;
  endfunction

  logic                    w_s1_ready;
  logic                    w_s2_ready;
  logic                    w_in_fire;
  logic [LANES-1:0]        w_in_neg;
  logic [LANES*DATA_W-1:0] w_act;

  logic                    r_vld_p1;
  logic [LANES*DATA_W-1:0] r_data_p1;
  logic [LANES-1:0]        r_neg_p1;
  mode_e                   r_mode_p1;

  logic                    r_vld_p2;
  logic [LANES*DATA_W-1:0] r_data_p2;

  // A stage may load when it is empty or when the stage after it is emptying.
  // That lets a beat enter S1 while S2 is stalled, so capacity is two beats.
  assign w_s2_ready = !r_vld_p2 || out_ready;
  assign w_s1_ready = !r_vld_p1 || w_s2_ready;
  // Ready is held high during reset, but no beat is taken in that cycle.
  assign in_ready   = w_s1_ready || rst;
  assign w_in_fire  = in_valid && w_s1_ready && !rst;

  always_comb begin
    w_in_neg = '0;
    for (int i = 0; i < LANES; i++) begin
      w_in_neg[i] = in_data[i*DATA_W + DATA_W - 1];
    end
  end

  // ---- stage p1: capture input vector, mode and per-lane sign ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_data_p1 <= in_data;
      r_mode_p1 <= mode_e'(in_mode);
      r_neg_p1  <= w_in_neg;
    end
  end

  always_comb begin
    w_act = '0;
    for (int i = 0; i < LANES; i++) begin
      w_act[i*DATA_W +: DATA_W] = f_activate(r_data_p1[i*DATA_W +: DATA_W],
                                             r_neg_p1[i], r_mode_p1);
    end
  end

  // ---- stage p2: register activation result, drives the output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
    end else if (w_s2_ready) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= w_act;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;

`ifdef ACTIVATION_PIPE_STATS_EN
  function automatic logic [31:0] f_sat_add(
    input logic [31:0]      acc,
    input logic [CNT_W-1:0] inc
  );
    logic [32:0] sum;
    sum = {1'b0, acc} + 33'(inc);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic [CNT_W-1:0] w_neg_cnt;
  logic [31:0]      r_stat_cnt;

  always_comb begin
    w_neg_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_neg_cnt = w_neg_cnt + CNT_W'(w_in_neg[i]);
    end
  end

  // Clear takes priority over a beat accepted on the same edge.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_stat_cnt <= '0;
    end else if (w_in_fire) begin
      r_stat_cnt <= f_sat_add(r_stat_cnt, w_neg_cnt);
    end
  end

  assign stat_neg_cnt = r_stat_cnt;
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stat_neg_cnt      = '0;
`endif

endmodule

// File: tb/tb_activation_pipe.sv
module tb_activation_pipe;

  localparam int     LANES      = 8;
  localparam int     DATA_W     = 32;
  localparam int     FRAC_W     = 16;
  localparam int     LEAK_SHIFT = 3;
  localparam longint CLIP       = 64'(6) << FRAC_W;
  localparam int     VW         = LANES * DATA_W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          stat_clr;
  logic [31:0]   stat_neg_cnt;

  activation_pipe #(
    .LANES(LANES), .DATA_W(DATA_W), .FRAC_W(FRAC_W),
    .LEAK_SHIFT(LEAK_SHIFT), .CLIP_VAL(CLIP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stat_clr(stat_clr), .stat_neg_cnt(stat_neg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_total = 0;
  int            n_bad   = 0;
  int            n_recv  = 0;
  logic [VW-1:0] exp_q[$];
  longint        m_cnt = 0;
  bit            prev_stall = 0;
  logic [VW-1:0] prev_data;
  bit            last_fire = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference activation, written with plain integer arithmetic.
  function automatic logic [DATA_W-1:0] ref_lane(input longint x, input int mode);
    longint y;
    longint d;
    d = longint'(1) << LEAK_SHIFT;
    case (mode)
      0: y = x;
      1: y = (x < 0) ? 0 : x;
      2: y = (x < 0) ? (x - (d - 1)) / d : x;   // floor division
      default: y = (x < 0) ? 0 : ((x > CLIP) ? CLIP : x);
    endcase
    return y[DATA_W-1:0];
  endfunction

  function automatic longint lane_val(input logic [VW-1:0] v, input int i);
    logic signed [DATA_W-1:0] s;
    s = v[i*DATA_W +: DATA_W];
    return longint'(s);
  endfunction

  function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] v, input logic [1:0] m);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = ref_lane(lane_val(v, i), int'(m));
    return r;
  endfunction

  function automatic int neg_lanes(input logic [VW-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++) if (lane_val(v, i) < 0) n++;
    return n;
  endfunction

  function automatic logic [VW-1:0] pk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_lane();
    case ($urandom % 6)
      0: return $urandom;
      1: return DATA_W'(int'($urandom_range(0, 2097152)) - 1048576);
      2: return DATA_W'(CLIP + longint'($urandom_range(0, 4)) - 2);
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = rnd_lane();
    return v;
  endfunction

  // One cycle: inputs were set after the previous falling edge. Observe the
  // handshake that the next rising edge will act on, update the scoreboard,
  // then move to the next falling edge.
  task automatic tick();
    #1;
    last_fire = 0;
    if (rst) begin
      check("in_ready_during_rst", in_ready, 1);
      exp_q.delete();
      m_cnt = 0;
      prev_stall = 0;
    end else begin
      check("stat_neg_cnt", stat_neg_cnt, m_cnt[31:0]);
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_data, 'x);
        else check("out_data", out_data, exp_q.pop_front());
        n_recv++;
      end
      if (in_valid && in_ready) begin
        last_fire = 1;
        exp_q.push_back(ref_vec(in_data, in_mode));
`ifdef ACTIVATION_PIPE_STATS_EN
        if (!stat_clr) begin
          m_cnt += neg_lanes(in_data);
          if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
        end
`endif
      end
`ifdef ACTIVATION_PIPE_STATS_EN
      if (stat_clr) m_cnt = 0;
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0;
    tick();
    rst = 0;
  endtask

  // Send one beat into an idle pipe and return its output and latency.
  task automatic single(input logic [VW-1:0] v, input logic [1:0] m,
                        output logic [VW-1:0] got, output int lat);
    out_ready = 1; in_valid = 1; in_data = v; in_mode = m;
    #1;
    check("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 0;
    lat = -1;
    got = '0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      if (out_valid && lat < 0) begin got = out_data; lat = i; end
      tick();
      if (lat >= 0) break;
    end
  endtask

  logic [VW-1:0] got;
  int            lat;
  int            sent;
  int            rec0;
  bit            saw_block;
  logic [VW-1:0] beats[20];

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_mode = 0; out_ready = 1; stat_clr = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, '0);
    check("rst_stat", stat_neg_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // ReLU single beat, latency 2
    single(pk(32'hFFFF0000, 32'h0, 32'h00028000, 32'hFFF90000,
              32'h00010000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000), 2'd1, got, lat);
    check("relu_lat", lat, 2);
    check("relu_data", got, pk(32'h0, 32'h0, 32'h00028000, 32'h0,
                               32'h00010000, 32'h0, 32'h7FFFFFFF, 32'h0));

    // leaky ReLU
    single(pk(32'hFFF80000, 32'hFFFFFFFF, 32'h80000000, 32'h00040000,
              32'h0, 32'h0, 32'h0, 32'h0), 2'd2, got, lat);
    check("leaky_lat", lat, 2);
    check("leaky_data", got, pk(32'hFFFF0000, 32'hFFFFFFFF, 32'hF0000000, 32'h00040000,
                                32'h0, 32'h0, 32'h0, 32'h0));

    // clipped ReLU
    single(pk(32'h00070000, 32'h00060000, 32'h0005FFBE, 32'hFFFF8000,
              32'h00060001, 32'h0, 32'h0, 32'h0), 2'd3, got, lat);
    check("clip_data", got, pk(32'h00060000, 32'h00060000, 32'h0005FFBE, 32'h0,
                               32'h00060000, 32'h0, 32'h0, 32'h0));

    // back-to-back beats cycling modes 0..3
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_data = rnd_vec(); in_mode = 2'(k);
      tick();
      check("b2b_accept", last_fire, 1);
    end
    in_valid = 0;
    for (int k = 0; k < 4; k++) tick();
    check("b2b_drained", exp_q.size(), 0);

    // statistics: 8, 0, 5 negatives then clear with a 4-negative beat
    do_reset();
    in_valid = 1; in_mode = 0;
    in_data = {LANES{32'hFFFF_0000}}; tick();
    in_data = {LANES{32'h0001_0000}}; tick();
    in_data = pk(32'hFFFFFFFF, 32'h80000000, 32'hFFFF8000, 32'hFFF00000, 32'hFFFFFFF0,
                 32'h1, 32'h2, 32'h0); tick();
    in_valid = 0;
    tick(); tick();
    #1;
`ifdef ACTIVATION_PIPE_STATS_EN
    check("stat_13", stat_neg_cnt, 13);
`else
    check("stat_off", stat_neg_cnt, 0);
`endif
    stat_clr = 1; in_valid = 1;
    in_data = pk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h1, 32'h1);
    tick();
    stat_clr = 0; in_valid = 0;
    tick(); tick(); tick();
    #1;
    check("stat_clear", stat_neg_cnt, 0);

    // 20-beat stream with out_ready low for cycles 5..9
    for (int k = 0; k < 20; k++) beats[k] = rnd_vec();
    sent = 0; rec0 = n_recv; saw_block = 0;
    for (int c = 0; c < 200 && (sent < 20 || exp_q.size() != 0); c++) begin
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (sent < 20);
      in_data   = beats[sent % 20];
      in_mode   = 2'(sent);
      #1;
      if (c >= 5 && c <= 9 && !in_ready) saw_block = 1;
      tick();
      if (last_fire) sent++;
    end
    in_valid = 0; out_ready = 1;
    check("stream_in_ready_drop", saw_block, 1);
    check("stream_sent", sent, 20);
    check("stream_recv", n_recv - rec0, 20);

    // reset with two beats in flight
    out_ready = 0;
    in_valid = 1; in_data = rnd_vec(); in_mode = 1; tick();
    in_data = rnd_vec(); tick();
    in_valid = 0;
    #1;
    check("inflight_full", in_ready, 0);
    rst = 1; in_valid = 1; in_data = {LANES{32'h8000_0000}};
    tick();
    rst = 0; in_valid = 0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_stat", stat_neg_cnt, 0);
    rec0 = n_recv;
    out_ready = 1;
    for (int k = 0; k < 6; k++) tick();
    check("rst_mid_no_out", n_recv - rec0, 0);

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_data   = rnd_vec();
      in_mode   = 2'($urandom);
      stat_clr  = ($urandom % 50) == 0;
      tick();
    end
    in_valid = 0; out_ready = 1; stat_clr = 0;
    for (int k = 0; k < 10; k++) tick();
    check("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
